// File: rtl/char_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_classifier_pkg
// Description : Shared limits and the packed entry-word layout of the classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package char_classifier_pkg;

    localparam int C_MAX_ENTRIES = 16;
    localparam int C_INDEX_WIDTH = 4;
    localparam int C_COUNT_WIDTH = 16;
    localparam logic [C_COUNT_WIDTH-1:0] C_COUNT_MAX = '1;

    // Entry word, LSB first: mask | hi | lo | enable
    function automatic int entry_width(input int dw, input int mw);
        return mw + 2 * dw + 1;
    endfunction

    function automatic int entry_hi_lsb(input int dw, input int mw);
        return mw + 0 * dw;
    endfunction

    function automatic int entry_lo_lsb(input int dw, input int mw);
        return mw + dw;
    endfunction

    function automatic int entry_en_bit(input int dw, input int mw);
        return mw + 2 * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_classifier_entry.sv
`default_nettype none
// ============================================================================
// Module      : char_classifier_entry
// Description : One classifier table entry: stored range/mask and range compare.
// Revision    : 1.0 - initial release
// ============================================================================
module char_classifier_entry
    import char_classifier_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_lo,
    input  logic [DATA_WIDTH-1:0] wr_hi,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] sym,
    output logic                  match,
    output logic [MASK_WIDTH-1:0] mask
);

    localparam int C_EW     = entry_width(DATA_WIDTH, MASK_WIDTH);
    localparam int C_HI_LSB = entry_hi_lsb(DATA_WIDTH, MASK_WIDTH);
    localparam int C_LO_LSB = entry_lo_lsb(DATA_WIDTH, MASK_WIDTH);
    localparam int C_EN_BIT = entry_en_bit(DATA_WIDTH, MASK_WIDTH);

    logic [C_EW-1:0]       r_entry;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH-1:0] w_hi;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_entry <= '0;
        end else if (wr_en) begin
            r_entry <= {wr_enable, wr_lo, wr_hi, wr_mask};
        end
    end

    assign w_lo  = r_entry[C_LO_LSB +: DATA_WIDTH];
    assign w_hi  = r_entry[C_HI_LSB +: DATA_WIDTH];
    assign mask  = r_entry[MASK_WIDTH-1:0];
    // lo > hi naturally yields no match, no special case needed
    assign match = r_entry[C_EN_BIT] && (w_lo <= sym) && (sym <= w_hi);

endmodule
`default_nettype wire

// File: rtl/char_classifier.sv
`default_nettype none
// ============================================================================
// Module      : char_classifier
// Description : Two-stage AXIS symbol classifier against a range/mask table.
// Revision    : 1.0 - initial release
// ============================================================================
module char_classifier
    import char_classifier_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MASK_WIDTH = 8,
    parameter int ENTRIES    = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                     aclk,
    input  logic                     areset,

    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,

    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [MASK_WIDTH-1:0]    m_axis_tdata,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic                     m_axis_thit,
    output logic [C_INDEX_WIDTH-1:0] m_axis_tindex,

    input  logic                     cfg_wr_en,
    input  logic [C_INDEX_WIDTH-1:0] cfg_addr,
    input  logic [DATA_WIDTH-1:0]    cfg_lo,
    input  logic [DATA_WIDTH-1:0]    cfg_hi,
    input  logic [MASK_WIDTH-1:0]    cfg_mask,
    input  logic                     cfg_enable,

    input  logic                     or_mode,
    input  logic [MASK_WIDTH-1:0]    default_mask,

    output logic [C_COUNT_WIDTH-1:0] hit_count,
    input  logic                     hit_clear
);

    logic                     w_en;
    logic [ENTRIES-1:0]       w_match;
    logic [MASK_WIDTH-1:0]    w_mask [ENTRIES];
    logic [MASK_WIDTH-1:0]    w_top_mask;
    logic [MASK_WIDTH-1:0]    w_or_mask;
    logic [C_INDEX_WIDTH-1:0] w_top_idx;

    logic                     r_s1_valid;
    logic [ENTRIES-1:0]       r_s1_match;
    logic [USER_WIDTH-1:0]    r_s1_user;
    logic [MASK_WIDTH-1:0]    r_s1_top_mask;
    logic [MASK_WIDTH-1:0]    r_s1_or_mask;
    logic [C_INDEX_WIDTH-1:0] r_s1_idx;

    logic                     r_m_valid;
    logic [MASK_WIDTH-1:0]    r_m_data;
    logic [USER_WIDTH-1:0]    r_m_user;
    logic                     r_m_hit;
    logic [C_INDEX_WIDTH-1:0] r_m_idx;
    logic [C_COUNT_WIDTH-1:0] r_hit_count;

    // Address decode only reaches instantiated entries, so out-of-range writes fall away
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        char_classifier_entry #(
            .DATA_WIDTH (DATA_WIDTH),
            .MASK_WIDTH (MASK_WIDTH)
        ) u_entry (
            .aclk      (aclk),
            .areset    (areset),
            .wr_en     (cfg_wr_en && (cfg_addr == C_INDEX_WIDTH'(gi))),
            .wr_lo     (cfg_lo),
            .wr_hi     (cfg_hi),
            .wr_mask   (cfg_mask),
            .wr_enable (cfg_enable),
            .sym       (s_axis_tdata),
            .match     (w_match[gi]),
            .mask      (w_mask[gi])
        );
    end

    always_comb begin
        w_top_mask = '0;
        w_or_mask  = '0;
        w_top_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_match[i]) begin
                w_top_mask = w_mask[i];
                w_or_mask  = w_or_mask | w_mask[i];
                w_top_idx  = C_INDEX_WIDTH'(i);
            end
        end
    end

    assign w_en          = m_axis_tready | ~r_m_valid;
    assign s_axis_tready = w_en;

    // Masks are captured with the match vector so a later table write cannot alter a beat in flight
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_s1_valid    <= 1'b0;
            r_s1_match    <= '0;
            r_s1_user     <= '0;
            r_s1_top_mask <= '0;
            r_s1_or_mask  <= '0;
            r_s1_idx      <= '0;
        end else if (w_en) begin
            r_s1_valid    <= s_axis_tvalid;
            r_s1_match    <= w_match;
            r_s1_user     <= s_axis_tuser;
            r_s1_top_mask <= w_top_mask;
            r_s1_or_mask  <= w_or_mask;
            r_s1_idx      <= w_top_idx;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_user  <= '0;
            r_m_hit   <= 1'b0;
            r_m_idx   <= '0;
        end else if (w_en) begin
            r_m_valid <= r_s1_valid;
            r_m_user  <= r_s1_user;
            if (|r_s1_match) begin
                r_m_hit  <= 1'b1;
                r_m_idx  <= r_s1_idx;
                r_m_data <= or_mode ? r_s1_or_mask : r_s1_top_mask;
            end else begin
                r_m_hit  <= 1'b0;
                r_m_idx  <= '0;
                r_m_data <= default_mask;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_hit_count <= '0;
        end else if (hit_clear) begin
            r_hit_count <= '0;
        end else if (r_m_valid && m_axis_tready && r_m_hit && (r_hit_count != C_COUNT_MAX)) begin
            r_hit_count <= r_hit_count + C_COUNT_WIDTH'(1);
        end
    end

    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tuser  = r_m_user;
    assign m_axis_thit   = r_m_hit;
    assign m_axis_tindex = r_m_idx;
    assign hit_count     = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_char_classifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_classifier
// Description : Directed + randomized self-checking bench for char_classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_classifier;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = '0;
    logic [0:0]  s_tuser = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [7:0]  m_tdata;
    logic [0:0]  m_tuser;
    logic        m_thit;
    logic [3:0]  m_tindex;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_lo = '0;
    logic [7:0]  cfg_hi = '0;
    logic [7:0]  cfg_mask = '0;
    logic        cfg_enable = 1'b0;
    logic        or_mode = 1'b0;
    logic [7:0]  default_mask = '0;
    logic [15:0] hit_count;
    logic        hit_clear = 1'b0;

    always #5 aclk = ~aclk;

    char_classifier dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_thit   (m_thit),
        .m_axis_tindex (m_tindex),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_addr      (cfg_addr),
        .cfg_lo        (cfg_lo),
        .cfg_hi        (cfg_hi),
        .cfg_mask      (cfg_mask),
        .cfg_enable    (cfg_enable),
        .or_mode       (or_mode),
        .default_mask  (default_mask),
        .hit_count     (hit_count),
        .hit_clear     (hit_clear)
    );

    typedef struct {
        logic [7:0] data;
        logic [0:0] user;
        logic       hit;
        logic [3:0] idx;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  t_lo [8];
    logic [7:0]  t_hi [8];
    logic [7:0]  t_mask [8];
    bit          t_en [8];
    int          m_cnt;
    int          n_assert;
    int          n_fail;
    int          n_out;
    logic [7:0]  last_data;
    logic        last_hit;
    logic [3:0]  last_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference classification straight from the range/mask rules
    function automatic exp_t classify(input logic [7:0] sym, input logic [0:0] user);
        exp_t       e;
        logic [7:0] acc;
        acc    = '0;
        e.hit  = 1'b0;
        e.idx  = '0;
        e.user = user;
        for (int i = 0; i < 8; i++) begin
            if (t_en[i] && (t_lo[i] <= sym) && (sym <= t_hi[i])) begin
                e.hit = 1'b1;
                e.idx = 4'(i);
                acc   = or_mode ? (acc | t_mask[i]) : t_mask[i];
            end
        end
        e.data = e.hit ? acc : default_mask;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            t_lo[i] = '0; t_hi[i] = '0; t_mask[i] = '0; t_en[i] = 1'b0;
        end
    endtask

    // One clock: check/update the model on pre-edge handshakes, then check post-edge state
    task automatic cycle();
        exp_t       e;
        logic       out_hs, in_hs, stall;
        logic [7:0] sn_data;
        logic [0:0] sn_user;
        logic       sn_hit;
        logic [3:0] sn_idx;
        #1;
        out_hs  = m_tvalid & m_tready;
        in_hs   = s_tvalid & s_tready;
        stall   = m_tvalid & ~m_tready;
        sn_data = m_tdata; sn_user = m_tuser; sn_hit = m_thit; sn_idx = m_tindex;
        if (out_hs) begin
            if (q.size() == 0) begin
                chk("spurious_beat", {31'd0, m_tvalid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("tdata", {24'd0, m_tdata}, {24'd0, e.data});
                chk("tuser", {31'd0, m_tuser}, {31'd0, e.user});
                chk("thit", {31'd0, m_thit}, {31'd0, e.hit});
                chk("tindex", {28'd0, m_tindex}, {28'd0, e.idx});
                last_data = m_tdata; last_hit = m_thit; last_idx = m_tindex;
                n_out++;
                if (!hit_clear && e.hit && m_cnt < 16'hFFFF) m_cnt++;
            end
        end
        if (hit_clear) m_cnt = 0;
        if (in_hs) q.push_back(classify(s_tdata, s_tuser));
        if (cfg_wr_en && cfg_addr < 4'd8) begin
            t_lo[cfg_addr[2:0]]   = cfg_lo;
            t_hi[cfg_addr[2:0]]   = cfg_hi;
            t_mask[cfg_addr[2:0]] = cfg_mask;
            t_en[cfg_addr[2:0]]   = cfg_enable;
        end
        @(posedge aclk);
        #1;
        if (stall) begin
            chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
            chk("stall_data", {24'd0, m_tdata}, {24'd0, sn_data});
            chk("stall_user", {31'd0, m_tuser}, {31'd0, sn_user});
            chk("stall_hit", {31'd0, m_thit}, {31'd0, sn_hit});
            chk("stall_idx", {28'd0, m_tindex}, {28'd0, sn_idx});
        end
        chk("hit_count", {16'd0, hit_count}, 32'(m_cnt));
    endtask

    task automatic wr_entry(input logic [3:0] a, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] mk, input logic en);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_lo = lo; cfg_hi = hi; cfg_mask = mk; cfg_enable = en;
        cycle();
        cfg_wr_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] sym, input logic [0:0] user);
        s_tvalid = 1'b1; s_tdata = sym; s_tuser = user;
        cycle();
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0 && !m_tvalid) break;
            cycle();
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int n0;
        int acc;
        int budget;
        bit pat [4];
        n_assert = 0; n_fail = 0; n_out = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, m_tdata}, 32'd0);
        chk("rst_thit", {31'd0, m_thit}, 32'd0);
        chk("rst_tindex", {28'd0, m_tindex}, 32'd0);
        chk("rst_tuser", {31'd0, m_tuser}, 32'd0);
        chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
        areset = 1'b0;
        #1;
        chk("rst_tready", {31'd0, s_tready}, 32'd1);

        // Highest-match and OR combining
        m_tready = 1'b1;
        default_mask = 8'hA5;
        wr_entry(4'd0, "a", "z", 8'h01, 1'b1);
        wr_entry(4'd3, "e", "e", 8'h08, 1'b1);
        send("e", 1'b1); drain();
        chk("hi_e_data", {24'd0, last_data}, 32'h08);
        chk("hi_e_idx", {28'd0, last_idx}, 32'd3);
        chk("hi_e_hit", {31'd0, last_hit}, 32'd1);
        send("b", 1'b0); drain();
        chk("hi_b_data", {24'd0, last_data}, 32'h01);
        chk("hi_b_idx", {28'd0, last_idx}, 32'd0);
        or_mode = 1'b1;
        send("e", 1'b0); drain();
        chk("or_e_data", {24'd0, last_data}, 32'h09);
        send("#", 1'b1); drain();
        chk("nomatch_data", {24'd0, last_data}, 32'hA5);
        chk("nomatch_hit", {31'd0, last_hit}, 32'd0);
        chk("nomatch_idx", {28'd0, last_idx}, 32'd0);
        or_mode = 1'b0;

        // Write and accept on the same edge: beat sees the old table
        s_tvalid = 1'b1; s_tdata = "c"; s_tuser = 1'b0;
        cfg_wr_en = 1'b1; cfg_addr = 4'd0; cfg_lo = "a"; cfg_hi = "z"; cfg_mask = 8'h10; cfg_enable = 1'b1;
        cycle();
        s_tvalid = 1'b0; cfg_wr_en = 1'b0;
        drain();
        chk("same_edge_old", {24'd0, last_data}, 32'h01);
        send("c", 1'b0); drain();
        chk("after_write_new", {24'd0, last_data}, 32'h10);
        wr_entry(4'd15, 8'h00, 8'hFF, 8'hFF, 1'b1);
        send("#", 1'b0); drain();
        chk("addr15_ignored_hit", {31'd0, last_hit}, 32'd0);
        chk("addr15_ignored_data", {24'd0, last_data}, 32'hA5);

        // Randomized stream with ready pattern 1,0,0,1 and live table writes
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 8; i++)
            wr_entry(4'(i), 8'($urandom_range(8'h20, 8'h60)), 8'($urandom_range(8'h40, 8'h7F)),
                     8'($urandom), 1'($urandom_range(0, 3) != 0));
        n0 = n_out; acc = 0; budget = 0;
        while (acc < 32 && budget < 600) begin
            m_tready = pat[budget % 4];
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = 8'($urandom_range(8'h20, 8'h7F));
            s_tuser  = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                cfg_wr_en = 1'b1; cfg_addr = 4'($urandom_range(0, 15));
                cfg_lo = 8'($urandom_range(8'h20, 8'h60)); cfg_hi = 8'($urandom_range(8'h40, 8'h7F));
                cfg_mask = 8'($urandom); cfg_enable = 1'($urandom);
            end
            #1;
            if (s_tvalid && s_tready) acc++;
            cycle();
            cfg_wr_en = 1'b0;
            budget++;
        end
        s_tvalid = 1'b0;
        drain();
        chk("stream_count", 32'(n_out - n0), 32'd32);

        // Saturating hit counter
        wr_entry(4'd7, 8'h00, 8'hFF, 8'h80, 1'b1);
        hit_clear = 1'b1; cycle(); hit_clear = 1'b0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            s_tdata = 8'($urandom);
            cycle();
        end
        s_tvalid = 1'b0;
        drain();
        chk("cnt_fffe", {16'd0, hit_count}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
        drain();
        chk("cnt_saturate", {16'd0, hit_count}, 32'h0000FFFF);
        send("x", 1'b0);
        cycle();
        chk("clear_hs_valid", {31'd0, m_tvalid}, 32'd1);
        hit_clear = 1'b1; cycle(); hit_clear = 1'b0;
        chk("clear_priority", {16'd0, hit_count}, 32'd0);
        drain();

        // Reset with two beats in flight
        send("a", 1'b1);
        send("b", 1'b0);
        areset = 1'b1;
        #1;
        chk("midrst_tvalid_async", {31'd0, m_tvalid}, 32'd0);
        @(posedge aclk);
        #1;
        chk("midrst_tvalid", {31'd0, m_tvalid}, 32'd0);
        model_reset();
        areset = 1'b0;
        #1;
        chk("midrst_tready", {31'd0, s_tready}, 32'd1);
        chk("midrst_count", {16'd0, hit_count}, 32'd0);
        n0 = n_out;
        send("a", 1'b0); drain();
        chk("midrst_one_beat", 32'(n_out - n0), 32'd1);
        chk("midrst_table_off_hit", {31'd0, last_hit}, 32'd0);
        chk("midrst_table_off_data", {24'd0, last_data}, 32'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/char_classifier.md
CHAR_CLASSIFIER -- requirements
Module: char_classifier

Interface
REQ-001 Parameter DATA_WIDTH, default 8: input symbol width in bits.
REQ-002 Parameter MASK_WIDTH, default 8: class mask width in bits.
REQ-003 Parameter ENTRIES, default 8, legal range 1..16: number of table entries.
REQ-004 Parameter USER_WIDTH, default 1: sideband width carried alongside each beat.
REQ-005 Port aclk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port areset, input, 1: reset, asynchronous, active-high.
REQ-007 Ports s_axis_tvalid/s_axis_tready/s_axis_tdata/s_axis_tuser, in/out/in/in, 1/1/DATA_WIDTH/USER_WIDTH: input stream.
REQ-008 Ports m_axis_tvalid/m_axis_tready/m_axis_tdata/m_axis_tuser, out/in/out/out, 1/1/MASK_WIDTH/USER_WIDTH: output stream, tdata = class mask.
REQ-009 Ports m_axis_thit/m_axis_tindex, out/out, 1/4: any-entry-matched flag; index of the highest matching entry.
REQ-010 Ports cfg_wr_en/cfg_addr/cfg_lo/cfg_hi/cfg_mask/cfg_enable, in, 1/4/DATA_WIDTH/DATA_WIDTH/MASK_WIDTH/1: table write port.
REQ-011 Ports or_mode/default_mask, in, 1/MASK_WIDTH: combine mode; mask emitted on no match.
REQ-012 Ports hit_count/hit_clear, out/in, 16/1: saturating count of beats with hit; synchronous clear.

Function
REQ-013 Entry i SHALL match when enabled and cfg_lo[i] <= s_axis_tdata <= cfg_hi[i], unsigned; lo == hi gives an exact-character match; lo > hi never matches.
REQ-014 cfg_wr_en with cfg_addr < ENTRIES SHALL write all four fields of that entry on the edge; cfg_addr >= ENTRIES SHALL be ignored.
REQ-015 Pipeline of two stages: stage 1 registers the match vector, tuser and valid; stage 2 registers the output; latency accept-edge to m_axis_tvalid = 2 cycles.
REQ-016 or_mode=0: tdata = mask of the highest-index matching entry. or_mode=1: tdata = bitwise OR of all matching masks.
REQ-017 No match: tdata = default_mask, thit = 0, tindex = 0; or_mode and default_mask sampled at stage 2.
REQ-018 Advance enable en = m_axis_tready | ~m_axis_tvalid; s_axis_tready = en; both stages hold all contents while en = 0.
REQ-019 Output SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rules); no beat dropped or duplicated.
REQ-020 A table write on edge k SHALL affect only beats accepted after edge k; a beat already in stage 1 keeps its registered match vector.
REQ-021 Simultaneous write and accept on the same edge: the beat SHALL be compared against the pre-write table.
REQ-022 hit_count SHALL increment on each output handshake with thit=1 and saturate at 16'hFFFF; hit_clear takes priority over increment on the same edge.
REQ-023 Sustained throughput SHALL be one beat per cycle while m_axis_tready=1.

Reset
REQ-024 On areset: all entries disabled with lo/hi/mask = 0; both stage valids, m_axis_tvalid, m_axis_tdata, m_axis_thit, m_axis_tindex, m_axis_tuser and hit_count = 0.
REQ-025 Reset mid-operation SHALL discard in-flight beats with no output handshake; s_axis_tready = 1 in the first cycle after deassertion.

Structure
REQ-026 A shared package char_classifier_pkg SHALL hold the entry field layout, the ENTRIES limit (16), the index width (4) and the counter width (16).
REQ-027 One sub-module, char_classifier_entry, SHALL hold one entry's registers and its range compare; ENTRIES instances generated.

Verification
REQ-028 Entry 0 = 'a'..'z' mask 0x01, entry 3 = 'e'..'e' mask 0x08, or_mode=0; send 'e' -> tdata 0x08, tindex 3, thit 1; send 'b' -> tdata 0x01, tindex 0.
REQ-029 Same table, or_mode=1, send 'e' -> tdata 0x09; send '#' with default_mask 0xA5 -> tdata 0xA5, thit 0.
REQ-030 Stream 32 beats while m_axis_tready toggles 1,0,0,1 -> 32 outputs in order, tuser intact, tdata stable during stalls.
REQ-031 Write entry 0 mask 0x10 on the same edge 'c' is accepted -> 'c' emits 0x01; next 'c' emits 0x10; cfg_addr 15 with ENTRIES=8 -> no effect.
REQ-032 Preload hit_count to 0xFFFE via 3 hit beats -> saturates at 0xFFFF; hit_clear with a hit handshake on the same edge -> 0.
REQ-033 Assert areset with 2 beats in flight -> m_axis_tvalid 0 next cycle, table disabled, s_axis_tready 1 after release.
